dcache_ctrl_nway: RTL and testbench
===================================

DCACHE_CTRL_NWAY -- requirements
Module: dcache_ctrl_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, meaning associativity (power of two, 1..8).
REQ-002 SHALL have parameter SET_BITS, default 7, meaning index width (sets = 2**SET_BITS).
REQ-003 SHALL have parameter LINE_WORDS, default 8, meaning 32-bit words per line (power of two, 2..16); OW = log2(LINE_WORDS).
REQ-004 SHALL have ports: clk in 1 clock; resetn in 1 reset (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have ports: cpu_req in 1 access request; cpu_wr in 1 write; cpu_index in SET_BITS set; cpu_offset in OW word; cpu_wstrb in 4 byte enables; cpu_wdata in 32; cpu_ready out 1 access completes this cycle.
REQ-006 SHALL have ports: hit_way in WAYS one-hot tag match; line_valid in WAYS; line_dirty in WAYS (metadata of cpu_index set).
REQ-007 SHALL have ports: arr_way out WAYS one-hot; arr_offset out OW; arr_we out 1; arr_wstrb out 4; arr_wdata out 32; arr_rdata in 32 (combinational read of arr_way/arr_offset); meta_we out 1; meta_valid out 1; meta_dirty out 1.
REQ-008 SHALL have ports: victim_way out WAYS one-hot (external tag mux builds write-back address); rd_req out 1; rd_addr_ok in 1; rd_data_ok in 1; rd_rdata in 32.
REQ-009 SHALL have ports: wr_req out 1; wr_addr_ok in 1; wr_valid out 1; wr_ready in 1; wr_wdata out 32; wr_wlast out 1; wr_resp in 1 write-burst response.

Function
REQ-010 SHALL implement states IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, DONE.
REQ-011 IDLE, cpu_req, hit_way!=0: SHALL assert cpu_ready same cycle; write hit drives arr_we=1, arr_way=hit_way, arr_offset=cpu_offset, arr_wstrb=cpu_wstrb, arr_wdata=cpu_wdata, meta_we=1, meta_valid=1, meta_dirty=1; read hit asserts no writes.
REQ-012 IDLE, cpu_req, miss: SHALL latch cpu_index, victim way; victim = lowest invalid way if any, else round-robin pointer of that set; next state WB_ADDR if victim valid and dirty, else RD_ADDR.
REQ-013 SHALL keep one round-robin pointer per set (log2(WAYS) bits), advanced modulo WAYS only on DONE when no invalid way was chosen.
REQ-014 WB_ADDR: wr_req=1 until wr_addr_ok sampled high, then WB_DATA with beat counter 0.
REQ-015 WB_DATA: arr_way=victim, arr_offset=beat, wr_wdata=arr_rdata, wr_valid=1; beat increments only on wr_valid&wr_ready; wr_wlast=1 when beat==LINE_WORDS-1; after last accepted beat go WB_RESP.
REQ-016 WB_RESP: wait wr_resp=1, then RD_ADDR; write-back is complete before refill starts.
REQ-017 RD_ADDR: rd_req=1 until rd_addr_ok high, then RD_DATA with beat 0.
REQ-018 RD_DATA: on each rd_data_ok write rd_rdata to arr_way=victim, arr_offset=beat, arr_wstrb=4'hF, arr_we=1; beat wraps to 0 after LINE_WORDS-1 and state goes DONE; rd_data_ok low stalls beat.
REQ-019 DONE: meta_we=1, meta_valid=1, meta_dirty=0 for victim; next IDLE, where the retried access hits.
REQ-020 cpu_ready SHALL be 0 in every state except IDLE hit; cpu_req inputs SHALL be ignored outside IDLE.
REQ-021 rd_addr_ok/wr_addr_ok in same cycle as request assertion SHALL complete the address phase that cycle.
REQ-022 Beat counter width OW, wrapping exactly at LINE_WORDS; no state skips beats.

Reset
REQ-023 resetn low SHALL asynchronously force state IDLE, beat 0, all round-robin pointers 0, victim_way 0, and every output 0.
REQ-024 resetn low mid-burst SHALL abort the burst; no recovery beats are issued after release.

Structure
REQ-025 State enum, OW/log2(WAYS) width functions, burst-channel constants SHALL live in shared package dcache_pkg.
REQ-026 Victim selection (invalid-first + per-set round-robin table) SHALL be sub-module dcache_victim_sel.

Verification
REQ-027 Write hit, WAYS=2, hit_way=2'b10, wstrb=4'b0011, wdata=32'hAABBCCDD -> same-cycle cpu_ready=1, arr_we=1, meta_dirty=1, arr_way=2'b10.
REQ-028 Clean miss, line_valid=2'b01 -> victim_way=2'b10, rd_req until addr_ok, 8 arr_we beats offsets 0..7, DONE meta_dirty=0, pointer unchanged.
REQ-029 Dirty miss, all valid, way0 dirty, pointer 0 -> 8 write beats, wr_wlast only on beat 7, wr_ready low 3 cycles mid-burst stalls beat, waits wr_resp, then refill.
REQ-030 Two consecutive full-set misses on set 5 -> victims way0 then way1, pointer back to 0 after WAYS=2 refills.
REQ-031 resetn pulsed low during RD_DATA beat 3 -> all outputs 0 immediately, IDLE after release, no further arr_we.
REQ-032 LINE_WORDS=16, WAYS=4, rd_data_ok every other cycle -> 16 beats, counter wraps to 0, DONE exactly once.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the n-way data cache controller: FSM states,
// width helpers and burst-channel constants.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_ADDR = 3'd1,
    WB_DATA = 3'd2,
    WB_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    DONE    = 3'd6
  } state_t;

  // Refill beats always overwrite the whole word
  localparam logic [3:0] FULL_WSTRB = 4'hF;

  // Word-offset width for a line of line_words 32-bit words
  function automatic int offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  // Round-robin pointer width; a direct-mapped cache still keeps one bit
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Victim way selection: lowest invalid way wins, otherwise the per-set
// round-robin pointer picks the way to evict.
module dcache_victim_sel
  import dcache_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int SET_BITS = 7
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [SET_BITS-1:0] lookup_index,
  input  logic [WAYS-1:0]     line_valid,
  input  logic                advance,
  input  logic [SET_BITS-1:0] advance_index,
  output logic [WAYS-1:0]     victim,
  output logic                invalid_found
);

  localparam int PW   = way_bits(WAYS);
  localparam int SETS = 2 ** SET_BITS;

  logic [PW-1:0] rr_ptr [SETS];
  logic [PW-1:0] cur_ptr;

  // Pick the lowest invalid way, falling back to the set's round-robin pointer
  always_comb begin
    victim        = '0;
    invalid_found = 1'b0;
    cur_ptr       = rr_ptr[lookup_index];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!line_valid[w]) begin
        victim        = '0;
        victim[w]     = 1'b1;
        invalid_found = 1'b1;
      end
    end
    if (!invalid_found) begin
      victim = WAYS'(1) << cur_ptr;
    end
  end

  // Advance the pointer of the refilled set modulo WAYS
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SETS; s++) begin
        rr_ptr[s] <= '0;
      end
    end else if (advance) begin
      if (rr_ptr[advance_index] == PW'(WAYS - 1)) begin
        rr_ptr[advance_index] <= '0;
      end else begin
        rr_ptr[advance_index] <= rr_ptr[advance_index] + PW'(1);
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl_nway.sv
// N-way data cache controller: same-cycle hits, dirty-victim write-back
// burst, line refill burst and metadata update.
module dcache_ctrl_nway
  import dcache_pkg::*;
#(
  parameter  int WAYS       = 2,
  parameter  int SET_BITS   = 7,
  parameter  int LINE_WORDS = 8,
  localparam int OW         = offset_bits(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cpu_req,
  input  logic                cpu_wr,
  input  logic [SET_BITS-1:0] cpu_index,
  input  logic [OW-1:0]       cpu_offset,
  input  logic [3:0]          cpu_wstrb,
  input  logic [31:0]         cpu_wdata,
  output logic                cpu_ready,
  input  logic [WAYS-1:0]     hit_way,
  input  logic [WAYS-1:0]     line_valid,
  input  logic [WAYS-1:0]     line_dirty,
  output logic [WAYS-1:0]     arr_way,
  output logic [OW-1:0]       arr_offset,
  output logic                arr_we,
  output logic [3:0]          arr_wstrb,
  output logic [31:0]         arr_wdata,
  input  logic [31:0]         arr_rdata,
  output logic                meta_we,
  output logic                meta_valid,
  output logic                meta_dirty,
  output logic [WAYS-1:0]     victim_way,
  output logic                rd_req,
  input  logic                rd_addr_ok,
  input  logic                rd_data_ok,
  input  logic [31:0]         rd_rdata,
  output logic                wr_req,
  input  logic                wr_addr_ok,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [31:0]         wr_wdata,
  output logic                wr_wlast,
  input  logic                wr_resp
);

  localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);

  state_t              state;
  logic [OW-1:0]       beat;
  logic [SET_BITS-1:0] miss_index;
  logic                rr_used;
  logic [WAYS-1:0]     sel_victim;
  logic                sel_invalid;
  logic                miss;

  assign miss = cpu_req && (hit_way == '0);

  dcache_victim_sel #(
    .WAYS     (WAYS),
    .SET_BITS (SET_BITS)
  ) u_victim_sel (
    .clk           (clk),
    .resetn        (resetn),
    .lookup_index  (cpu_index),
    .line_valid    (line_valid),
    .advance       ((state == DONE) && rr_used),
    .advance_index (miss_index),
    .victim        (sel_victim),
    .invalid_found (sel_invalid)
  );

  // Miss sequencing: latch the victim, write back if dirty, refill, update metadata
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      beat       <= '0;
      victim_way <= '0;
      miss_index <= '0;
      rr_used    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            miss_index <= cpu_index;
            victim_way <= sel_victim;
            rr_used    <= !sel_invalid;
            beat       <= '0;
            state      <= (|(sel_victim & line_valid & line_dirty)) ? WB_ADDR : RD_ADDR;
          end
        end
        WB_ADDR: begin
          if (wr_addr_ok) begin
            beat  <= '0;
            state <= WB_DATA;
          end
        end
        WB_DATA: begin
          if (wr_ready) begin
            beat <= beat + OW'(1);
            if (beat == LAST_BEAT) state <= WB_RESP;
          end
        end
        WB_RESP: begin
          if (wr_resp) state <= RD_ADDR;
        end
        RD_ADDR: begin
          if (rd_addr_ok) begin
            beat  <= '0;
            state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rd_data_ok) begin
            beat <= beat + OW'(1);
            if (beat == LAST_BEAT) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array, metadata and bus strobes decoded from state; all held at 0 in reset
  always_comb begin
    cpu_ready  = 1'b0;
    arr_way    = '0;
    arr_offset = '0;
    arr_we     = 1'b0;
    arr_wstrb  = '0;
    arr_wdata  = '0;
    meta_we    = 1'b0;
    meta_valid = 1'b0;
    meta_dirty = 1'b0;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    wr_valid   = 1'b0;
    wr_wdata   = '0;
    wr_wlast   = 1'b0;
    if (resetn) begin
      case (state)
        IDLE: begin
          if (cpu_req && (hit_way != '0)) begin
            cpu_ready  = 1'b1;
            arr_way    = hit_way;
            arr_offset = cpu_offset;
            if (cpu_wr) begin
              arr_we     = 1'b1;
              arr_wstrb  = cpu_wstrb;
              arr_wdata  = cpu_wdata;
              meta_we    = 1'b1;
              meta_valid = 1'b1;
              meta_dirty = 1'b1;
            end
          end
        end
        WB_ADDR: wr_req = 1'b1;
        WB_DATA: begin
          arr_way    = victim_way;
          arr_offset = beat;
          wr_valid   = 1'b1;
          wr_wdata   = arr_rdata;
          wr_wlast   = (beat == LAST_BEAT);
        end
        RD_ADDR: rd_req = 1'b1;
        RD_DATA: begin
          arr_way    = victim_way;
          arr_offset = beat;
          if (rd_data_ok) begin
            arr_we    = 1'b1;
            arr_wstrb = FULL_WSTRB;
            arr_wdata = rd_rdata;
          end
        end
        DONE: begin
          arr_way    = victim_way;
          meta_we    = 1'b1;
          meta_valid = 1'b1;
          meta_dirty = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// Directed bench for dcache_ctrl_nway: a 2-way/8-word instance for hits,
// misses, write-back and reset abort, and a 4-way/16-word refill instance.
`timescale 1ns/1ps
module tb_dcache_ctrl_nway;

  logic clk = 1'b0;
  logic resetn;

  int check_count = 0;
  int pass_count  = 0;

  // Instance A: WAYS=2, SET_BITS=7, LINE_WORDS=8
  logic        cpu_req_a, cpu_wr_a, cpu_ready_a;
  logic [6:0]  cpu_index_a;
  logic [2:0]  cpu_offset_a, arr_offset_a;
  logic [3:0]  cpu_wstrb_a, arr_wstrb_a;
  logic [31:0] cpu_wdata_a, arr_wdata_a, arr_rdata_a, rd_rdata_a, wr_wdata_a;
  logic [1:0]  hit_way_a, line_valid_a, line_dirty_a, arr_way_a, victim_way_a;
  logic        arr_we_a, meta_we_a, meta_valid_a, meta_dirty_a;
  logic        rd_req_a, rd_addr_ok_a, rd_data_ok_a;
  logic        wr_req_a, wr_addr_ok_a, wr_valid_a, wr_ready_a, wr_wlast_a, wr_resp_a;

  // Instance B: WAYS=4, SET_BITS=3, LINE_WORDS=16
  logic        cpu_req_b, cpu_ready_b;
  logic [2:0]  cpu_index_b;
  logic [3:0]  arr_offset_b, arr_wstrb_b;
  logic [31:0] arr_wdata_b, rd_rdata_b, wr_wdata_b;
  logic [3:0]  hit_way_b, line_valid_b, arr_way_b, victim_way_b;
  logic        arr_we_b, meta_we_b, meta_valid_b, meta_dirty_b;
  logic        rd_req_b, rd_addr_ok_b, rd_data_ok_b;
  logic        wr_req_b, wr_valid_b, wr_wlast_b;

  // Data array model: each word encodes its way and offset
  assign arr_rdata_a = {16'hC0DE, 6'd0, arr_way_a, 5'd0, arr_offset_a};

  always #5 clk = ~clk;

  dcache_ctrl_nway #(.WAYS(2), .SET_BITS(7), .LINE_WORDS(8)) dut_a (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req_a), .cpu_wr(cpu_wr_a), .cpu_index(cpu_index_a),
    .cpu_offset(cpu_offset_a), .cpu_wstrb(cpu_wstrb_a), .cpu_wdata(cpu_wdata_a),
    .cpu_ready(cpu_ready_a),
    .hit_way(hit_way_a), .line_valid(line_valid_a), .line_dirty(line_dirty_a),
    .arr_way(arr_way_a), .arr_offset(arr_offset_a), .arr_we(arr_we_a),
    .arr_wstrb(arr_wstrb_a), .arr_wdata(arr_wdata_a), .arr_rdata(arr_rdata_a),
    .meta_we(meta_we_a), .meta_valid(meta_valid_a), .meta_dirty(meta_dirty_a),
    .victim_way(victim_way_a),
    .rd_req(rd_req_a), .rd_addr_ok(rd_addr_ok_a), .rd_data_ok(rd_data_ok_a),
    .rd_rdata(rd_rdata_a),
    .wr_req(wr_req_a), .wr_addr_ok(wr_addr_ok_a), .wr_valid(wr_valid_a),
    .wr_ready(wr_ready_a), .wr_wdata(wr_wdata_a), .wr_wlast(wr_wlast_a),
    .wr_resp(wr_resp_a)
  );

  dcache_ctrl_nway #(.WAYS(4), .SET_BITS(3), .LINE_WORDS(16)) dut_b (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req_b), .cpu_wr(1'b0), .cpu_index(cpu_index_b),
    .cpu_offset(4'd0), .cpu_wstrb(4'd0), .cpu_wdata(32'd0),
    .cpu_ready(cpu_ready_b),
    .hit_way(hit_way_b), .line_valid(line_valid_b), .line_dirty(4'b0000),
    .arr_way(arr_way_b), .arr_offset(arr_offset_b), .arr_we(arr_we_b),
    .arr_wstrb(arr_wstrb_b), .arr_wdata(arr_wdata_b), .arr_rdata(32'd0),
    .meta_we(meta_we_b), .meta_valid(meta_valid_b), .meta_dirty(meta_dirty_b),
    .victim_way(victim_way_b),
    .rd_req(rd_req_b), .rd_addr_ok(rd_addr_ok_b), .rd_data_ok(rd_data_ok_b),
    .rd_rdata(rd_rdata_b),
    .wr_req(wr_req_b), .wr_addr_ok(1'b0), .wr_valid(wr_valid_b),
    .wr_ready(1'b0), .wr_wdata(wr_wdata_b), .wr_wlast(wr_wlast_b),
    .wr_resp(1'b0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic applyStimulus(input logic req, input logic wr, input logic [6:0] index,
                               input logic [2:0] offset, input logic [3:0] wstrb,
                               input logic [31:0] wdata, input logic [1:0] hit,
                               input logic [1:0] valid, input logic [1:0] dirty);
    cpu_req_a    = req;
    cpu_wr_a     = wr;
    cpu_index_a  = index;
    cpu_offset_a = offset;
    cpu_wstrb_a  = wstrb;
    cpu_wdata_a  = wdata;
    hit_way_a    = hit;
    line_valid_a = valid;
    line_dirty_a = dirty;
  endtask

  // Full miss on instance A, optionally with a dirty write-back stalled at beat 4
  task automatic runMiss(input logic [6:0] index, input logic [1:0] valid,
                         input logic [1:0] dirty, input logic [1:0] exp_victim,
                         input bit exp_wb);
    int beat;
    int guard;
    int stalls;
    nextCycle();
    applyStimulus(1'b1, 1'b0, index, 3'd0, 4'h0, 32'h0, 2'b00, valid, dirty);
    settle();
    checkOutput("miss_ready", {31'd0, cpu_ready_a}, 32'd0);
    nextCycle();
    cpu_req_a = 1'b0;
    settle();
    checkOutput("victim", {30'd0, victim_way_a}, {30'd0, exp_victim});
    if (exp_wb) begin
      checkOutput("wb_addr_req", {30'd0, rd_req_a, wr_req_a}, 32'd1);
      nextCycle();
      wr_addr_ok_a = 1'b1;
      settle();
      checkOutput("wb_addr_ok", {31'd0, wr_req_a}, 32'd1);
      nextCycle();
      wr_addr_ok_a = 1'b0;
      beat   = 0;
      guard  = 0;
      stalls = 0;
      while (beat < 8 && guard < 40) begin
        wr_ready_a = !(beat == 4 && stalls < 3);
        settle();
        checkOutput("wb_valid", {31'd0, wr_valid_a}, 32'd1);
        checkOutput("wb_offset", {29'd0, arr_offset_a}, beat);
        checkOutput("wb_wdata", wr_wdata_a, {16'hC0DE, 6'd0, exp_victim, 5'd0, beat[2:0]});
        checkOutput("wb_wlast", {31'd0, wr_wlast_a}, {31'd0, beat == 7});
        if (wr_ready_a) beat++;
        else stalls++;
        guard++;
        nextCycle();
      end
      checkOutput("wb_beats", beat, 32'd8);
      wr_ready_a = 1'b0;
      for (int i = 0; i < 2; i++) begin
        settle();
        checkOutput("wb_resp_wait", {29'd0, rd_req_a, wr_valid_a, wr_req_a}, 32'd0);
        nextCycle();
      end
      wr_resp_a = 1'b1;
      settle();
      checkOutput("wb_resp_no_rd", {31'd0, rd_req_a}, 32'd0);
      nextCycle();
      wr_resp_a = 1'b0;
      settle();
    end
    checkOutput("rd_req_wait", {30'd0, wr_req_a, rd_req_a}, 32'd1);
    nextCycle();
    rd_addr_ok_a = 1'b1;
    settle();
    checkOutput("rd_req_ok", {31'd0, rd_req_a}, 32'd1);
    nextCycle();
    rd_addr_ok_a = 1'b0;
    for (int b = 0; b < 8; b++) begin
      rd_data_ok_a = 1'b1;
      rd_rdata_a   = 32'h5A5A0000 + b;
      settle();
      checkOutput("rf_we", {31'd0, arr_we_a}, 32'd1);
      checkOutput("rf_offset", {29'd0, arr_offset_a}, b);
      checkOutput("rf_way", {30'd0, arr_way_a}, {30'd0, exp_victim});
      checkOutput("rf_data", {arr_wstrb_a, arr_wdata_a[27:0]},
                  {4'hF, 28'hA5A0000 + 28'(b)});
      nextCycle();
    end
    rd_data_ok_a = 1'b0;
    settle();
    checkOutput("done_meta", {28'd0, arr_we_a, meta_we_a, meta_valid_a, meta_dirty_a}, 32'h6);
    nextCycle();
    settle();
    checkOutput("back_idle", {29'd0, meta_we_a, rd_req_a, wr_req_a}, 32'd0);
  endtask

  initial begin
    int accepted;
    int done_count;
    logic exp_we;
    resetn       = 1'b0;
    rd_addr_ok_a = 1'b0; rd_data_ok_a = 1'b0; rd_rdata_a = '0;
    wr_addr_ok_a = 1'b0; wr_ready_a   = 1'b0; wr_resp_a  = 1'b0;
    cpu_req_b    = 1'b0; cpu_index_b  = '0;   hit_way_b  = '0; line_valid_b = '0;
    rd_addr_ok_b = 1'b0; rd_data_ok_b = 1'b0; rd_rdata_b = '0;
    applyStimulus(1'b1, 1'b1, 7'd1, 3'd3, 4'h3, 32'hAABBCCDD, 2'b10, 2'b11, 2'b00);
    #12;
    checkOutput("reset_outputs", {26'd0, cpu_ready_a, arr_we_a, meta_we_a, rd_req_a,
                                  victim_way_a}, 32'd0);
    nextCycle();
    resetn = 1'b1;

    // Write hit and read hit
    settle();
    checkOutput("wh_ready", {31'd0, cpu_ready_a}, 32'd1);
    checkOutput("wh_array", {arr_we_a, arr_way_a, arr_offset_a, arr_wstrb_a},
                {22'd0, 1'b1, 2'b10, 3'd3, 4'h3});
    checkOutput("wh_wdata", arr_wdata_a, 32'hAABBCCDD);
    checkOutput("wh_meta", {29'd0, meta_we_a, meta_valid_a, meta_dirty_a}, 32'h7);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 7'd1, 3'd5, 4'hF, 32'h12345678, 2'b01, 2'b11, 2'b00);
    settle();
    checkOutput("rh_ready", {31'd0, cpu_ready_a}, 32'd1);
    checkOutput("rh_no_write", {30'd0, arr_we_a, meta_we_a}, 32'd0);
    checkOutput("rh_way", {27'd0, arr_way_a, arr_offset_a}, {27'd0, 2'b01, 3'd5});

    // Clean miss into invalid way1, dirty write-back, round-robin on set 5, set 9 pointer
    runMiss(7'd9, 2'b01, 2'b00, 2'b10, 1'b0);
    runMiss(7'd5, 2'b11, 2'b01, 2'b01, 1'b1);
    runMiss(7'd5, 2'b11, 2'b00, 2'b10, 1'b0);
    runMiss(7'd5, 2'b11, 2'b00, 2'b01, 1'b0);
    runMiss(7'd9, 2'b11, 2'b00, 2'b01, 1'b0);

    // Reset pulse during refill beat 3
    nextCycle();
    applyStimulus(1'b1, 1'b0, 7'd20, 3'd0, 4'h0, 32'h0, 2'b00, 2'b00, 2'b00);
    nextCycle();
    cpu_req_a    = 1'b0;
    rd_addr_ok_a = 1'b1;
    settle();
    checkOutput("ra_victim", {30'd0, victim_way_a}, 32'd1);
    nextCycle();
    rd_addr_ok_a = 1'b0;
    rd_data_ok_a = 1'b1;
    for (int b = 0; b < 3; b++) nextCycle();
    #2;
    checkOutput("ra_beat3", {28'd0, arr_we_a, arr_offset_a}, {28'd0, 1'b1, 3'd3});
    resetn = 1'b0;
    #1;
    checkOutput("ra_outputs", {26'd0, arr_we_a, arr_offset_a, victim_way_a}, 32'd0);
    nextCycle();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checkOutput("ra_no_beats", {30'd0, arr_we_a, rd_req_a}, 32'd0);
      nextCycle();
    end
    rd_data_ok_a = 1'b0;

    // Instance B: 16-beat refill with rd_data_ok every other cycle
    cpu_req_b    = 1'b1;
    cpu_index_b  = 3'd2;
    line_valid_b = 4'b1011;
    settle();
    checkOutput("b_miss_ready", {31'd0, cpu_ready_b}, 32'd0);
    nextCycle();
    cpu_req_b    = 1'b0;
    rd_addr_ok_b = 1'b1;
    settle();
    checkOutput("b_victim", {27'd0, rd_req_b, victim_way_b}, {27'd0, 1'b1, 4'b0100});
    nextCycle();
    rd_addr_ok_b = 1'b0;
    accepted   = 0;
    done_count = 0;
    for (int c = 0; c < 40; c++) begin
      rd_data_ok_b = c[0];
      rd_rdata_b   = 32'hB0000000 + c;
      exp_we       = rd_data_ok_b && (accepted < 16);
      settle();
      checkOutput("b_we", {31'd0, arr_we_b}, {31'd0, exp_we});
      if (exp_we) begin
        checkOutput("b_offset", {24'd0, arr_way_b, arr_offset_b},
                    {24'd0, 4'b0100, 4'(accepted)});
        checkOutput("b_data", arr_wdata_b ^ {28'd0, arr_wstrb_b}, rd_rdata_b ^ 32'hF);
        accepted++;
      end
      if (meta_we_b) begin
        done_count++;
        checkOutput("b_done_meta", {30'd0, meta_valid_b, meta_dirty_b}, 32'h2);
      end
      nextCycle();
    end
    rd_data_ok_b = 1'b0;
    checkOutput("b_done_once", done_count, 32'd1);
    settle();
    checkOutput("b_idle", {25'd0, cpu_ready_b, rd_req_b, wr_req_b, wr_valid_b, wr_wlast_b,
                           meta_we_b, arr_we_b}, 32'd0);
    checkOutput("b_wr_wdata", wr_wdata_b, 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
